// File: rtl/axi2mem_rd_tcdm_if.sv
// Read-side TCDM interface for axi2mem: issues paired lane reads to two memory ports
// and merges the in-order lane responses into tagged 64-bit beats.
module axi2mem_rd_tcdm_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                trans_req_i,
    input  logic [1:0][ADDR_WIDTH-1:0] trans_add_i,
    input  logic [1:0][ID_WIDTH-1:0]  trans_id_i,
    input  logic [1:0]                trans_last_i,
    output logic [1:0]                trans_gnt_o,
    output logic [1:0]                tcdm_req_o,
    output logic [1:0][ADDR_WIDTH-1:0] tcdm_add_o,
    output logic [1:0]                tcdm_wen_o,
    output logic [1:0][3:0]           tcdm_be_o,
    input  logic [1:0]                tcdm_gnt_i,
    input  logic [1:0]                tcdm_r_valid_i,
    input  logic [1:0][31:0]          tcdm_r_rdata_i,
    output logic [63:0]               data_dat_o,
    output logic [ID_WIDTH-1:0]       data_id_o,
    output logic                      data_last_o,
    output logic                      data_gnt_o,
    input  logic                      data_req_i
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic             pop;
    logic [1:0]       accept;
    logic [1:0]       dat_avail;
    logic [1:0][31:0] dat_head;

    logic [ID_WIDTH:0] tag_mem [DEPTH];
    logic [PW-1:0]     tag_wp;
    logic [PW-1:0]     tag_rp;
    logic              unused_lane1_tag;

    assign pop = data_req_i & data_gnt_o;

    for (genvar k = 0; k < 2; k++) begin : g_lane
        logic [ADDR_WIDTH-1:0] cmd_mem [DEPTH];
        logic [PW-1:0]         cmd_wp;
        logic [PW-1:0]         cmd_rp;
        logic [CW-1:0]         cmd_cnt;
        logic [31:0]           dat_mem [DEPTH];
        logic [PW-1:0]         dat_wp;
        logic [PW-1:0]         dat_rp;
        logic [CW-1:0]         dat_cnt;
        logic [CW-1:0]         occ;
        logic [CW-1:0]         infl;
        logic                  issue;
        logic                  resp;

        // occ counts every beat from acceptance until pop, so no lane structure can overflow
        assign trans_gnt_o[k] = !rst_i && (occ < FULL);
        assign accept[k]      = trans_req_i[k] & trans_gnt_o[k];
        assign tcdm_req_o[k]  = !rst_i && (cmd_cnt != '0);
        assign tcdm_add_o[k]  = tcdm_req_o[k] ? cmd_mem[cmd_rp] : '0;
        assign issue          = tcdm_req_o[k] & tcdm_gnt_i[k];
        assign resp           = tcdm_r_valid_i[k] && (infl != '0);
        assign dat_avail[k]   = dat_cnt != '0;
        assign dat_head[k]    = dat_mem[dat_rp];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cmd_wp  <= '0;
                cmd_rp  <= '0;
                cmd_cnt <= '0;
                dat_wp  <= '0;
                dat_rp  <= '0;
                dat_cnt <= '0;
                occ     <= '0;
                infl    <= '0;
            end else begin
                if (accept[k]) cmd_wp <= cmd_wp + PW'(1);
                if (issue)     cmd_rp <= cmd_rp + PW'(1);
                if (resp)      dat_wp <= dat_wp + PW'(1);
                if (pop)       dat_rp <= dat_rp + PW'(1);

                case ({accept[k], issue})
                    2'b10:   cmd_cnt <= cmd_cnt + CW'(1);
                    2'b01:   cmd_cnt <= cmd_cnt - CW'(1);
                    default: ;
                endcase
                case ({accept[k], pop})
                    2'b10:   occ <= occ + CW'(1);
                    2'b01:   occ <= occ - CW'(1);
                    default: ;
                endcase
                case ({issue, resp})
                    2'b10:   infl <= infl + CW'(1);
                    2'b01:   infl <= infl - CW'(1);
                    default: ;
                endcase
                case ({resp, pop})
                    2'b10:   dat_cnt <= dat_cnt + CW'(1);
                    2'b01:   dat_cnt <= dat_cnt - CW'(1);
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (accept[k]) cmd_mem[cmd_wp] <= trans_add_i[k];
            if (resp)      dat_mem[dat_wp] <= tcdm_r_rdata_i[k];
        end
    end

    // Tags travel with lane 0 only; lane 1 id/last are redundant copies.
    assign unused_lane1_tag = ^{trans_id_i[1], trans_last_i[1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_wp <= '0;
            tag_rp <= '0;
        end else begin
            if (accept[0]) tag_wp <= tag_wp + PW'(1);
            if (pop)       tag_rp <= tag_rp + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept[0]) tag_mem[tag_wp] <= {trans_id_i[0], trans_last_i[0]};
    end

    assign data_gnt_o  = !rst_i && (&dat_avail);
    assign data_dat_o  = rst_i ? '0 : {dat_head[1], dat_head[0]};
    assign data_id_o   = rst_i ? '0 : tag_mem[tag_rp][ID_WIDTH:1];
    assign data_last_o = !rst_i && tag_mem[tag_rp][0];
    assign tcdm_wen_o  = 2'b11;
    assign tcdm_be_o   = {2{4'hF}};

endmodule
